rtc_bus_ctrl: RTL and testbench

- Bus-cycle engine directly downstream of the main sequencer FSM: consumes its enable_inicio / enable_escribir / enable_leer levels and posicion, executes the matching transactions on the RTC's multiplexed address/data bus, and returns a one-cycle listo pulse per completed command.
- Init command = one write from a fixed 4-entry table indexed by posicion.
- Read/write commands = burst of NUM_REGS consecutive registers starting at BASE_ADDR.

---
 rtl/rtc_bus_pkg.sv | 26 ++
 rtl/rtc_phase_timer.sv | 26 ++
 rtl/rtc_bus_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_rtc_bus_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared types and constant tables for the RTC multiplexed-bus controller.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_TURN,
    S_DATA,
    S_REC,
    S_DONE,
    S_HOLD
  } state_t;

  typedef enum logic [1:0] {
    CMD_INIT,
    CMD_WR,
    CMD_RD
  } cmd_t;

  localparam logic [7:0] INIT_ADDR [0:3] = '{8'h02, 8'h10, 8'h00, 8'hF0};
  localparam logic [7:0] INIT_DATA [0:3] = '{8'h10, 8'h00, 8'hD2, 8'h00};

  // Clocks spent in HOLD so lagging upstream enables cannot re-trigger.
  localparam int T_HOLD = 2;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing each bus phase; tc is high while the count is zero.
module rtc_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Executes init writes and register bursts on the RTC address/data bus.
// Commands are sampled in IDLE, run to completion, pulse listo, then sit in HOLD.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int         NUM_REGS  = 3,
  parameter logic [7:0] BASE_ADDR = 8'h21,
  parameter int         T_ADDR    = 4,
  parameter int         T_DATA    = 4,
  parameter int         T_REC     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_inicio,
  input  logic       enable_escribir,
  input  logic       enable_leer,
  input  logic [1:0] posicion,
  input  logic [7:0] data_wr,
  input  logic [7:0] ad_in,
  output logic       listo,
  output logic [2:0] byte_idx,
  output logic [7:0] data_rd,
  output logic       rd_valid,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] ad_out,
  output logic       ad_oe
);

  localparam logic [7:0] LD_ADDR  = 8'(T_ADDR - 1);
  localparam logic [7:0] LD_DATA  = 8'(T_DATA - 1);
  localparam logic [7:0] LD_REC   = 8'(T_REC - 1);
  localparam logic [7:0] LD_HOLD  = 8'(T_HOLD - 1);
  localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);

  state_t     state;
  cmd_t       cmd;
  cmd_t       next_cmd;
  logic [1:0] pos_q;
  logic       go;
  logic       has_cmd;
  logic       more;
  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_tc;
  logic [7:0] first_addr;
  logic [7:0] next_addr;

  rtc_phase_timer #(.W(8)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    has_cmd  = enable_inicio | enable_escribir | enable_leer;
    next_cmd = CMD_RD;
    if (enable_inicio) begin
      next_cmd = CMD_INIT;
    end else if (enable_escribir) begin
      next_cmd = CMD_WR;
    end
  end

  assign more       = (cmd != CMD_INIT) && (byte_idx < LAST_IDX);
  assign first_addr = (cmd == CMD_INIT) ? INIT_ADDR[pos_q] : BASE_ADDR;
  assign next_addr  = BASE_ADDR + {5'd0, byte_idx + 3'd1};

  // The timer is loaded on the same edge that enters each timed phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = 8'd0;
    case (state)
      S_IDLE: if (go) begin
        tmr_load = 1'b1;
        tmr_val  = LD_ADDR;
      end
      S_TURN: begin
        tmr_load = 1'b1;
        tmr_val  = LD_DATA;
      end
      S_DATA: if (tmr_tc) begin
        tmr_load = 1'b1;
        tmr_val  = LD_REC;
      end
      S_REC: if (tmr_tc && more) begin
        tmr_load = 1'b1;
        tmr_val  = LD_ADDR;
      end
      S_DONE: begin
        tmr_load = 1'b1;
        tmr_val  = LD_HOLD;
      end
      default: begin
        tmr_load = 1'b0;
        tmr_val  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cmd      <= CMD_INIT;
      pos_q    <= 2'd0;
      go       <= 1'b0;
      listo    <= 1'b0;
      byte_idx <= 3'd0;
      data_rd  <= 8'd0;
      rd_valid <= 1'b0;
      cs_n     <= 1'b1;
      rd_n     <= 1'b1;
      wr_n     <= 1'b1;
      a_d      <= 1'b0;
      ad_out   <= 8'd0;
      ad_oe    <= 1'b0;
    end else begin
      listo    <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            go     <= 1'b0;
            state  <= S_ADDR;
            cs_n   <= 1'b0;
            a_d    <= 1'b0;
            ad_oe  <= 1'b1;
            ad_out <= first_addr;
          end else if (has_cmd) begin
            cmd      <= next_cmd;
            go       <= 1'b1;
            byte_idx <= 3'd0;
            if (enable_inicio) pos_q <= posicion;
          end
        end
        S_ADDR: if (tmr_tc) begin
          state <= S_TURN;
          cs_n  <= 1'b1;
          ad_oe <= 1'b0;
        end
        S_TURN: begin
          state <= S_DATA;
          cs_n  <= 1'b0;
          a_d   <= 1'b1;
          if (cmd == CMD_RD) begin
            rd_n <= 1'b0;
          end else begin
            wr_n   <= 1'b0;
            ad_oe  <= 1'b1;
            ad_out <= (cmd == CMD_INIT) ? INIT_DATA[pos_q] : data_wr;
          end
        end
        S_DATA: if (tmr_tc) begin
          state <= S_REC;
          cs_n  <= 1'b1;
          rd_n  <= 1'b1;
          wr_n  <= 1'b1;
          a_d   <= 1'b0;
          ad_oe <= 1'b0;
          if (cmd == CMD_RD) begin
            data_rd  <= ad_in;
            rd_valid <= 1'b1;
          end
        end
        S_REC: if (tmr_tc) begin
          if (more) begin
            byte_idx <= byte_idx + 3'd1;
            state    <= S_ADDR;
            cs_n     <= 1'b0;
            ad_oe    <= 1'b1;
            ad_out   <= next_addr;
          end else begin
            state <= S_DONE;
            listo <= 1'b1;
          end
        end
        S_DONE: state <= S_HOLD;
        S_HOLD: if (tmr_tc) begin
          // Leaving HOLD doubles as the next IDLE sample point.
          state <= S_IDLE;
          if (has_cmd) begin
            cmd      <= next_cmd;
            go       <= 1'b1;
            byte_idx <= 3'd0;
            if (enable_inicio) pos_q <= posicion;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Scoreboard bench for rtc_bus_ctrl: stimulus queues expected bus cycles, reads and listo times.
module tb_rtc_bus_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable_inicio, enable_escribir, enable_leer;
  logic [1:0] posicion;
  logic [7:0] data_wr;
  logic [7:0] ad_in;
  logic       listo, rd_valid, cs_n, rd_n, wr_n, a_d, ad_oe;
  logic [2:0] byte_idx;
  logic [7:0] data_rd, ad_out;

  rtc_bus_ctrl dut (
    .clk(clk), .reset(reset),
    .enable_inicio(enable_inicio), .enable_escribir(enable_escribir),
    .enable_leer(enable_leer), .posicion(posicion), .data_wr(data_wr),
    .ad_in(ad_in), .listo(listo), .byte_idx(byte_idx), .data_rd(data_rd),
    .rd_valid(rd_valid), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
    .ad_out(ad_out), .ad_oe(ad_oe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_wr;
    logic [7:0] addr;
    logic [7:0] data;
  } bus_t;

  bus_t bus_q[$];
  logic [7:0] rd_q[$];
  int listo_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%h required=none at cycle %0d", name, act, cyc);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Bus-side models: write data follows byte_idx, read data is handed out per read strobe.
  logic [7:0] wr_tab [0:7];
  logic [7:0] rd_vals [0:4];
  int rd_ptr = 0;
  logic prev_rd = 1'b1;

  assign data_wr = wr_tab[byte_idx];

  always @(negedge clk) begin
    if (prev_rd && !rd_n && rd_ptr < 5) begin
      ad_in = rd_vals[rd_ptr];
      rd_ptr++;
    end
    prev_rd = rd_n;
  end

  // Monitor
  logic       prev_cs = 1'b1, prev_ad = 1'b0, turn_pend = 1'b0;
  logic [3:0] alen = 0, dlen = 0;
  logic       obs_wr = 0;
  logic [7:0] obs_addr = 0, obs_data = 0;

  always @(negedge clk) begin
    chk("no_rd_wr_overlap", {31'd0, !rd_n && !wr_n}, 32'd0);
    chk("no_oe_during_rd", {31'd0, ad_oe && !rd_n}, 32'd0);
    if (reset) begin
      prev_cs = 1'b1; prev_ad = 1'b0; turn_pend = 1'b0;
      alen = 0; dlen = 0; obs_wr = 0; obs_addr = 0; obs_data = 0;
    end else begin
      if (turn_pend) begin
        chk("turn_len", {30'd0, cs_n, a_d}, {30'd0, 1'b0, 1'b1});
        turn_pend = 1'b0;
      end
      if (!prev_cs && !prev_ad && cs_n) turn_pend = 1'b1;
      if (!cs_n && !a_d) begin
        alen++;
        obs_addr = ad_out;
        chk("addr_oe", {31'd0, ad_oe}, 32'd1);
      end
      if (!cs_n && a_d && (!wr_n || !rd_n)) dlen++;
      if (!cs_n && a_d && !wr_n) begin
        obs_wr = 1'b1;
        obs_data = ad_out;
        chk("wr_oe", {31'd0, ad_oe}, 32'd1);
      end
      if (cs_n && !prev_cs && prev_ad) begin
        if (bus_q.size() == 0) unexpected("bus_cycle", {15'd0, obs_wr, obs_addr, obs_data});
        else chk("bus_cycle", {7'd0, obs_wr, obs_addr, obs_data, alen, dlen},
                 {7'd0, bus_q.pop_front(), 4'd4, 4'd4});
        alen = 0; dlen = 0; obs_wr = 0; obs_addr = 0; obs_data = 0;
      end
      prev_cs = cs_n;
      prev_ad = a_d;
    end
    if (rd_valid) begin
      if (rd_q.size() == 0) unexpected("rd_valid", {24'd0, data_rd});
      else chk("data_rd", {24'd0, data_rd}, {24'd0, rd_q.pop_front()});
    end
    if (listo) begin
      if (listo_q.size() == 0) unexpected("listo", cyc);
      else chk("listo_cycle", cyc, listo_q.pop_front());
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_strobes"}, {29'd0, cs_n, rd_n, wr_n}, 32'h7);
    chk({tag, "_a_d_oe"}, {30'd0, a_d, ad_oe}, 32'd0);
    chk({tag, "_ad_out"}, {24'd0, ad_out}, 32'd0);
    chk({tag, "_pulses"}, {30'd0, listo, rd_valid}, 32'd0);
    chk({tag, "_data_rd"}, {24'd0, data_rd}, 32'd0);
    chk({tag, "_byte_idx"}, {29'd0, byte_idx}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  logic [7:0] ia [0:3];
  logic [7:0] id [0:3];
  int t, n;

  initial begin
    ia[0] = 8'h02; ia[1] = 8'h10; ia[2] = 8'h00; ia[3] = 8'hF0;
    id[0] = 8'h10; id[1] = 8'h00; id[2] = 8'hD2; id[3] = 8'h00;
    for (int i = 0; i < 8; i++) wr_tab[i] = 8'h00;
    wr_tab[0] = 8'h59; wr_tab[1] = 8'h59; wr_tab[2] = 8'h23;
    rd_vals[0] = 8'h45; rd_vals[1] = 8'h30; rd_vals[2] = 8'h12;
    rd_vals[3] = 8'hA5; rd_vals[4] = 8'h00;
    ad_in = 8'h00;
    reset = 1'b1;
    enable_inicio = 0; enable_escribir = 0; enable_leer = 0;
    posicion = 2'd0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Init table walk: sample on edge t+1, listo 12 clocks later, next sample 3 after listo.
    t = cyc;
    enable_inicio = 1'b1;
    for (int p = 0; p < 4; p++) begin
      wait_cyc(t);
      posicion = 2'(p);
      bus_q.push_back({1'b1, ia[p], id[p]});
      listo_q.push_back(t + 13);
      t = t + 15;
    end
    wait_cyc(t - 2);
    enable_inicio = 1'b0;

    // Burst read of three registers.
    wait_cyc(t + 5);
    n = cyc;
    enable_leer = 1'b1;
    bus_q.push_back({1'b0, 8'h21, 8'h00});
    bus_q.push_back({1'b0, 8'h22, 8'h00});
    bus_q.push_back({1'b0, 8'h23, 8'h00});
    rd_q.push_back(8'h45); rd_q.push_back(8'h30); rd_q.push_back(8'h12);
    listo_q.push_back(n + 35);
    wait_cyc(n + 35);
    enable_leer = 1'b0;

    // Burst write, then both enables held through HOLD: a second write follows.
    wait_cyc(n + 45);
    n = cyc;
    enable_escribir = 1'b1;
    for (int r = 0; r < 2; r++) begin
      bus_q.push_back({1'b1, 8'h21, 8'h59});
      bus_q.push_back({1'b1, 8'h22, 8'h59});
      bus_q.push_back({1'b1, 8'h23, 8'h23});
    end
    listo_q.push_back(n + 35);
    listo_q.push_back(n + 72);
    wait_cyc(n + 35);
    enable_leer = 1'b1;
    wait_cyc(n + 72);
    enable_leer = 1'b0;
    enable_escribir = 1'b0;

    // Reset in the middle of byte 1's data phase of a read.
    wait_cyc(n + 82);
    n = cyc;
    enable_leer = 1'b1;
    bus_q.push_back({1'b0, 8'h21, 8'h00});
    rd_q.push_back(8'hA5);
    wait_cyc(n + 19);
    reset = 1'b1;
    enable_leer = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;

    // Back in IDLE: a fresh init command must run with normal latency.
    wait_cyc(n + 45);
    n = cyc;
    enable_inicio = 1'b1;
    posicion = 2'd2;
    bus_q.push_back({1'b1, 8'h00, 8'hD2});
    listo_q.push_back(n + 13);
    wait_cyc(n + 13);
    enable_inicio = 1'b0;
    wait_cyc(n + 30);

    chk("bus_q_drained", bus_q.size(), 32'd0);
    chk("rd_q_drained", rd_q.size(), 32'd0);
    chk("listo_q_drained", listo_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
